// File: rtl/dual_cam_pixel_feeder_pkg.sv
// Shared types and constants for the side-by-side dual-camera pixel feeder.
package dual_cam_pixel_feeder_pkg;

    typedef enum logic [1:0] {
        StWaitVs,
        StSync,
        StRun,
        StSkip
    } state_e;

    localparam int unsigned PixW   = 16;
    localparam int unsigned WordW  = PixW + 1;
    localparam int unsigned SofBit = PixW;

    localparam logic [PixW-1:0] FillColor = 16'hF800;

endpackage

// File: rtl/dual_cam_pixel_feeder_fifo_sof_aligner.sv
// Per-source frame aligner: drops untagged words from a FWFT FIFO head until an SOF-tagged
// word is waiting, which then stays at the head until the run phase consumes it.
module dual_cam_pixel_feeder_fifo_sof_aligner
    import dual_cam_pixel_feeder_pkg::*;
(
    input  logic             active,
    input  logic [WordW-1:0] dout,
    input  logic             empty,
    output logic             ready,
    output logic             flush_rd_en
);

    logic head_tag;

    always_comb begin
        head_tag    = dout[SofBit];
        ready       = !empty && head_tag;
        flush_rd_en = active && !empty && !head_tag;
    end

endmodule

// File: rtl/dual_cam_pixel_feeder.sv
// Serves HDMI timing-generator pixel requests: left half of each line from camera 0, right half
// from camera 1, both aligned to frame start via the SOF tag; underflows are filled and counted.
module dual_cam_pixel_feeder
    import dual_cam_pixel_feeder_pkg::*;
#(
    parameter int unsigned      H_DISP     = 1024,
    parameter int unsigned      V_DISP     = 768,
    parameter int unsigned      SPLIT      = H_DISP / 2,
    parameter logic [PixW-1:0]  FILL_COLOR = FillColor
) (
    input  logic             pixel_clk,
    input  logic             sys_rst,
    input  logic             video_vs,
    input  logic             data_req,
    output logic [PixW-1:0]  pixel_data,
    input  logic [WordW-1:0] fifo0_dout,
    input  logic             fifo0_empty,
    output logic             fifo0_rd_en,
    input  logic [WordW-1:0] fifo1_dout,
    input  logic             fifo1_empty,
    output logic             fifo1_rd_en,
    input  logic             status_clr,
    output logic             underflow_flag,
    output logic [15:0]      underflow_cnt,
    output logic [7:0]       skip_cnt
);

    localparam int unsigned ColW = (H_DISP > 1) ? $clog2(H_DISP) : 1;
    localparam int unsigned RowW = (V_DISP > 1) ? $clog2(V_DISP) : 1;

    state_e          state_q, state_d;
    logic            vs_q, req_q;
    logic [ColW-1:0] col_q, col_d;
    logic [RowW-1:0] row_q, row_d;
    logic [PixW-1:0] pixel_q, pixel_d;
    logic            flag_q, flag_d;
    logic [15:0]     ucnt_q, ucnt_d;
    logic [7:0]      scnt_q, scnt_d;

    logic frame_start, sel1, run_req, underflow, last_pix, skip_evt;
    logic ready0, ready1, flush0, flush1;

    dual_cam_pixel_feeder_fifo_sof_aligner u_align0 (
        .active      (state_q == StSync),
        .dout        (fifo0_dout),
        .empty       (fifo0_empty),
        .ready       (ready0),
        .flush_rd_en (flush0)
    );

    dual_cam_pixel_feeder_fifo_sof_aligner u_align1 (
        .active      (state_q == StSync),
        .dout        (fifo1_dout),
        .empty       (fifo1_empty),
        .ready       (ready1),
        .flush_rd_en (flush1)
    );

    always_comb begin
        frame_start = vs_q && !video_vs;
        sel1        = 32'(col_q) >= SPLIT;
        run_req     = (state_q == StRun) && data_req;
        underflow   = run_req && (sel1 ? fifo1_empty : fifo0_empty);
        last_pix    = (32'(row_q) == V_DISP - 1) && (32'(col_q) == H_DISP - 1);
        fifo0_rd_en = (run_req && !sel1 && !fifo0_empty) || flush0;
        fifo1_rd_en = (run_req && sel1 && !fifo1_empty) || flush1;
    end

    always_comb begin
        state_d  = state_q;
        skip_evt = 1'b0;
        unique case (state_q)
            StWaitVs: if (frame_start) state_d = StSync;
            StSync: begin
                // A request that arrives before both sources hold their SOF word loses the frame.
                if (!frame_start) begin
                    if (data_req && !(ready0 && ready1)) begin
                        state_d  = StSkip;
                        skip_evt = 1'b1;
                    end else if (ready0 && ready1) begin
                        state_d = StRun;
                    end
                end
            end
            StRun: begin
                if (frame_start)                state_d = StSync;
                else if (data_req && last_pix)  state_d = StWaitVs;
            end
            StSkip: if (frame_start) state_d = StSync;
            default: state_d = StWaitVs;
        endcase
    end

    always_comb begin
        col_d = '0;
        if (data_req) col_d = (32'(col_q) == H_DISP - 1) ? '0 : col_q + 1'b1;

        row_d = row_q;
        if (frame_start)              row_d = '0;
        else if (req_q && !data_req)  row_d = row_q + 1'b1;

        pixel_d = pixel_q;
        if (data_req) begin
            if (run_req && !underflow) pixel_d = sel1 ? fifo1_dout[PixW-1:0]
                                                      : fifo0_dout[PixW-1:0];
            else                       pixel_d = FILL_COLOR;
        end

        flag_d = flag_q;
        ucnt_d = ucnt_q;
        scnt_d = scnt_q;
        if (status_clr) begin
            flag_d = 1'b0;
            ucnt_d = '0;
            scnt_d = '0;
        end else begin
            if (underflow) begin
                flag_d = 1'b1;
                if (ucnt_q != 16'hFFFF) ucnt_d = ucnt_q + 1'b1;
            end
            if (skip_evt && scnt_q != 8'hFF) scnt_d = scnt_q + 1'b1;
        end
    end

    always_ff @(posedge pixel_clk) begin
        if (sys_rst) begin
            state_q <= StWaitVs;
            vs_q    <= 1'b0;
            req_q   <= 1'b0;
            col_q   <= '0;
            row_q   <= '0;
            pixel_q <= '0;
            flag_q  <= 1'b0;
            ucnt_q  <= '0;
            scnt_q  <= '0;
        end else begin
            state_q <= state_d;
            vs_q    <= video_vs;
            req_q   <= data_req;
            col_q   <= col_d;
            row_q   <= row_d;
            pixel_q <= pixel_d;
            flag_q  <= flag_d;
            ucnt_q  <= ucnt_d;
            scnt_q  <= scnt_d;
        end
    end

    assign pixel_data     = pixel_q;
    assign underflow_flag = flag_q;
    assign underflow_cnt  = ucnt_q;
    assign skip_cnt       = scnt_q;

endmodule
